// File: rtl/ct_spsram_ctrl_pkg.sv
// ct_spsram_ctrl_pkg: shared types and constants for the 256x144 single-port
// SRAM controller (FSM state encoding, default widths, last init address).
package ct_spsram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,  // zero-fill sweep of the whole array
    ST_RUN  = 1'b1   // normal request/response service
  } ctrl_state_e;

  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int DATA_WIDTH_DEF  = 144;
  localparam int RSP_ENTRIES_DEF = 2;

  // Last address written by the init sweep (256-deep macro).
  localparam int INIT_LAST = 255;

endpackage

// File: rtl/ct_spsram_ctrl_rspbuf.sv
// ct_spsram_ctrl_rspbuf: ENTRIES-deep valid/ready response FIFO for SRAM read
// data, with an optional bypass from the push port straight to the output.
//
// Build option: CT_SPSRAM_CTRL_RDATA_FLOP_EN
//   defined   - no bypass; every push lands in the FIFO first (out next cycle)
//   undefined - when empty, pushed data is presented on the output the same
//               cycle and only stored if the consumer does not take it
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears entries)
//   push, push_data one entry offered this cycle (SRAM Q of an in-flight read)
//   out_vld/out_rdy output handshake, out_data is the FIFO head (or bypass)
//   cnt             number of stored entries (excludes a bypassed push)
module ct_spsram_ctrl_rspbuf
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ENTRIES    = RSP_ENTRIES_DEF,
  parameter int CNT_W      = $clog2(ENTRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      cnt
);

  localparam int               PTR_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ENTRIES - 1);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0]      head, tail;
  logic                  empty, wr_en, rd_en;

  assign empty = (cnt == '0);

`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
  assign out_vld  = !empty;
  assign out_data = mem[head];
  assign wr_en    = push;
`else
  logic bypass;
  assign bypass   = push && empty;
  assign out_vld  = !empty || push;
  // Selecting on bypass (not on empty) keeps out_data at the cleared entry
  // after reset instead of exposing raw SRAM Q.
  assign out_data = bypass ? push_data : mem[head];
  // A bypassed entry taken by the consumer never needs storage.
  assign wr_en    = push && !(bypass && out_rdy);
`endif

  assign rd_en = !empty && out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= push_data;
        tail      <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
      end
      if (rd_en) head <= (head == PTR_LAST) ? '0 : head + 1'b1;
      if (wr_en && !rd_en)      cnt <= cnt + 1'b1;
      else if (!wr_en && rd_en) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ct_spsram_256x144_ctrl.sv
// ct_spsram_256x144_ctrl: initiator-side controller for the 256x144
// single-port SRAM macro. Zero-fills the array after reset, then turns a
// valid/ready request channel (read or bit-masked write) into SRAM cycles and
// returns read data through a small response FIFO.
//
// Build option: CT_SPSRAM_CTRL_RDATA_FLOP_EN (see ct_spsram_ctrl_rspbuf):
//   defined -> 2-cycle read latency, undefined -> 1-cycle with bypass.
//
// Ports:
//   forever_cpuclk, cpurst     clock, synchronous active-high reset
//   req_*                      request channel (req_wmask 1 = write that bit)
//   rsp_vld/rsp_rdy/rsp_rdata  read response channel
//   init_done                  array zero-fill finished
//   sram_a/cen/gwen/wen/d      SRAM macro inputs (active-low enables)
//   sram_q                     SRAM read data, valid the cycle after a read
module ct_spsram_256x144_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int RSP_ENTRIES = RSP_ENTRIES_DEF
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int                    CNT_W     = $clog2(RSP_ENTRIES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_LAST);
  localparam logic [CNT_W:0]        CREDITS   = (CNT_W + 1)'(RSP_ENTRIES);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  inflight;
  logic [CNT_W-1:0]      buf_cnt;
  logic [CNT_W:0]        credit_used;
  logic                  wr_acc, rd_acc;

  // A read consumes a credit from accept until its data leaves the buffer,
  // so a stalled consumer can never overflow the FIFO. Writes need none.
  assign credit_used = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight};
  assign req_rdy     = (state == ST_RUN) && (req_wr || (credit_used < CREDITS));
  assign wr_acc      = req_vld && req_rdy && req_wr;
  assign rd_acc      = req_vld && req_rdy && !req_wr;
  assign init_done   = (state == ST_RUN);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      inflight <= 1'b0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      inflight <= 1'b0;
      if (init_cnt == LAST_ADDR) state <= ST_RUN;
    end else begin
      inflight <= rd_acc;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = req_addr;
    sram_d    = req_wdata;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_d    = '0;
      sram_a    = init_cnt;
    end else if (wr_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
    end else if (rd_acc) begin
      sram_cen  = 1'b0;
    end
  end

  ct_spsram_ctrl_rspbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (RSP_ENTRIES),
    .CNT_W      (CNT_W)
  ) u_rspbuf (
    .clk       (forever_cpuclk),
    .rst       (cpurst),
    .push      (inflight),
    .push_data (sram_q),
    .out_vld   (rsp_vld),
    .out_rdy   (rsp_rdy),
    .out_data  (rsp_rdata),
    .cnt       (buf_cnt)
  );

endmodule
